prog_loader: RTL and testbench

Program loader for the 8-bit microprocessor. It receives a byte stream over a valid/ready handshake and assembles byte pairs into 16-bit instruction words. Each word is written into the instruction memory at consecutive addresses starting from 0, so this block is the writer for the memory the program counter reads from. While loading, it holds the CPU in reset through CPU_HOLD, which is OR'ed into the program counter reset.

---
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: assembles a big-endian byte stream into instruction words and writes them
// to instruction memory from address 0, holding the CPU in reset while a load is in flight.
module prog_loader #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned WordWidth = 16,
  parameter int unsigned Timeout   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth:0]   num_words_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic                 wr_en_o,
  output logic [AddrWidth-1:0] wr_addr_o,
  output logic [WordWidth-1:0] wr_data_o,
  output logic                 cpu_hold_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned IdleW = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam logic [IdleW-1:0]   IdleMax   = IdleW'(Timeout - 1);
  localparam logic [IdleW-1:0]   IdleOne   = IdleW'(1);
  localparam logic [AddrWidth:0] MaxWords  = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [AddrWidth:0] CountOne  = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);
  localparam bit                 TimeoutEn = (Timeout != 0);

  typedef enum logic [2:0] {StIdle, StHi, StLo, StWrite, StFin, StErr} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth:0]   count_q, count_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [WordWidth-1:0] data_q, data_d;
  logic [IdleW-1:0]     idle_q, idle_d;

  logic [AddrWidth:0] num_clamped;
  logic               xfer;
  logic               last_word;
  logic               idle_expired;

  assign num_clamped  = (num_words_i > MaxWords) ? MaxWords : num_words_i;
  assign byte_ready_o = (state_q == StHi) || (state_q == StLo);
  assign xfer         = byte_valid_i && byte_ready_o;
  // Compare against the count rather than incrementing past it, so the address never wraps.
  assign last_word    = (({1'b0, addr_q} + CountOne) == count_q);
  assign idle_expired = TimeoutEn && (idle_q == IdleMax);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idle_d  = '0;
    unique case (state_q)
      StIdle, StErr: begin
        if (start_i) begin
          count_d = num_clamped;
          addr_d  = '0;
          state_d = (num_clamped == '0) ? StFin : StHi;
        end
      end
      StHi: begin
        if (xfer) begin
          data_d[WordWidth-1 -: 8] = byte_i;
          state_d = StLo;
        end else begin
          idle_d = idle_q + IdleOne;
          if (idle_expired) state_d = StErr;
        end
      end
      StLo: begin
        if (xfer) begin
          data_d[7:0] = byte_i;
          state_d = StWrite;
        end else begin
          idle_d = idle_q + IdleOne;
          if (idle_expired) state_d = StErr;
        end
      end
      StWrite: begin
        if (last_word) begin
          state_d = StFin;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = StHi;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idle_q  <= idle_d;
    end
  end

  assign wr_en_o    = (state_q == StWrite);
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign busy_o     = (state_q == StHi) || (state_q == StLo) || (state_q == StWrite);
  assign cpu_hold_o = (state_q != StIdle);
  assign done_o     = (state_q == StFin);
  assign err_o      = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with Timeout=8: loads, count limits, gaps, timeout, resets.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  num_words = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, cpu_hold, busy, done, err;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int done_cnt = 0;
  int rdy_wr_cnt = 0;

  prog_loader #(
    .AddrWidth(4),
    .WordWidth(16),
    .Timeout  (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .num_words_i (num_words),
    .byte_i      (byte_in),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .cpu_hold_o  (cpu_hold),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Write/done log sampled mid-cycle; the tasks compare it against their own expectations.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (done) done_cnt++;
    if (wr_en && byte_ready) rdy_wr_cnt++;
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic push_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL push_byte: byte %02h not accepted, byte_ready=%b required 1", b, byte_ready);
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_done: done=%b required 1 within 200 cycles", tag, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] n);
    @(posedge clk);
    #1;
    num_words = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all 0",
               {byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({cpu_hold, busy, byte_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: hold/busy/ready=%b required 000", {cpu_hold, busy, byte_ready});
    end
  endtask

  task automatic test_two_word();
    int idx, d0;
    idx = wa_q.size();
    d0 = done_cnt;
    do_start(5'd2);
    n_cmp++;
    if ({busy, cpu_hold, byte_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL two_start: busy/hold/ready=%b required 111", {busy, cpu_hold, byte_ready});
    end
    push_byte(8'hA1);
    push_byte(8'h23);
    n_cmp++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 16'hA123}) begin
      n_fail++;
      $display("FAIL two_w0: en=%b addr=%0d data=%h required 1/0/a123", wr_en, wr_addr, wr_data);
    end
    push_byte(8'h5C);
    push_byte(8'h07);
    n_cmp++;
    if ({wr_en, byte_ready, wr_addr, wr_data} !== {2'b10, 4'd1, 16'h5C07}) begin
      n_fail++;
      $display("FAIL two_w1: en=%b ready=%b addr=%0d data=%h required 1/0/1/5c07",
               wr_en, byte_ready, wr_addr, wr_data);
    end
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, cpu_hold, wr_en} !== 3'b110) begin
      n_fail++;
      $display("FAIL two_done: done/hold/en=%b required 110", {done, cpu_hold, wr_en});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, cpu_hold} !== 2'b00) begin
      n_fail++;
      $display("FAIL two_release: done/hold=%b required 00", {done, cpu_hold});
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wa_q.size() - idx != 2 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL two_count: writes=%0d dones=%0d required 2/1", wa_q.size() - idx,
               done_cnt - d0);
    end
  endtask

  task automatic test_count(input logic [4:0] n, input string tag);
    int idx, d0;
    idx = wa_q.size();
    d0 = done_cnt;
    do_start(n);
    for (int i = 0; i < 32; i++) push_byte(pat(i));
    byte_valid = 1'b0;
    wait_done(tag);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wa_q.size() - idx != 16 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_count: writes=%0d dones=%0d required 16/1", tag, wa_q.size() - idx,
               done_cnt - d0);
    end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (wa_q[idx+k] !== 4'(k) || wd_q[idx+k] !== {pat(2*k), pat(2*k+1)}) begin
        n_fail++;
        $display("FAIL %s_word%0d: addr=%0d data=%h required %0d/%h", tag, k, wa_q[idx+k],
                 wd_q[idx+k], k, {pat(2*k), pat(2*k+1)});
      end
    end
    n_cmp++;
    if ({wr_addr, byte_ready, cpu_hold} !== {4'd15, 2'b00}) begin
      n_fail++;
      $display("FAIL %s_hold: addr=%0d ready=%b hold=%b required 15/0/0", tag, wr_addr,
               byte_ready, cpu_hold);
    end
  endtask

  task automatic test_zero();
    int idx;
    idx = wa_q.size();
    do_start(5'd0);
    n_cmp++;
    if ({done, busy, byte_ready, cpu_hold, wr_en} !== 5'b10010) begin
      n_fail++;
      $display("FAIL zero_fin: done/busy/ready/hold/en=%b required 10010",
               {done, busy, byte_ready, cpu_hold, wr_en});
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wa_q.size() != idx || done !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_nowrite: writes=%0d done=%b hold=%b required 0/0/0",
               wa_q.size() - idx, done, cpu_hold);
    end
  endtask

  task automatic test_gaps();
    int idx, r0, g;
    idx = wa_q.size();
    r0 = rdy_wr_cnt;
    do_start(5'd3);
    for (int i = 0; i < 6; i++) begin
      g = (i == 2) ? 0 : int'($urandom_range(0, 5));
      if (g > 0) begin
        byte_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      push_byte(pat(i + 100));
    end
    byte_valid = 1'b0;
    wait_done("gaps");
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wa_q.size() - idx != 3 || rdy_wr_cnt != r0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_count: writes=%0d ready_in_write=%0d err=%b required 3/0/0",
               wa_q.size() - idx, rdy_wr_cnt - r0, err);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (wa_q[idx+k] !== 4'(k) || wd_q[idx+k] !== {pat(2*k+100), pat(2*k+101)}) begin
        n_fail++;
        $display("FAIL gaps_word%0d: addr=%0d data=%h required %0d/%h", k, wa_q[idx+k],
                 wd_q[idx+k], k, {pat(2*k+100), pat(2*k+101)});
      end
    end
  endtask

  task automatic test_timeout();
    int idx;
    idx = wa_q.size();
    do_start(5'd2);
    push_byte(8'hA5);
    byte_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: err=%b after 7 idle cycles required 0", err);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({err, cpu_hold, busy, byte_ready} !== 4'b1100) begin
      n_fail++;
      $display("FAIL tmo_err: err/hold/busy/ready=%b required 1100",
               {err, cpu_hold, busy, byte_ready});
    end
    byte_valid = 1'b1;
    byte_in = 8'hEE;
    repeat (5) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || wa_q.size() != idx) begin
      n_fail++;
      $display("FAIL tmo_sticky: err=%b hold=%b writes=%0d required 1/1/0", err, cpu_hold,
               wa_q.size() - idx);
    end
    do_start(5'd1);
    n_cmp++;
    if ({err, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL tmo_restart: err/busy=%b required 01", {err, busy});
    end
    push_byte(8'h12);
    push_byte(8'h34);
    byte_valid = 1'b0;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 16'h1234}) begin
      n_fail++;
      $display("FAIL tmo_reload: en=%b addr=%0d data=%h required 1/0/1234", wr_en, wr_addr,
               wr_data);
    end
    wait_done("tmo");
  endtask

  task automatic test_timeout_edge();
    do_start(5'd1);
    push_byte(8'h11);
    byte_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    byte_in = 8'h22;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    n_cmp++;
    if ({err, wr_en, wr_data} !== {2'b01, 16'h1122}) begin
      n_fail++;
      $display("FAIL tmo_edge: err=%b en=%b data=%h required 0/1/1122", err, wr_en, wr_data);
    end
    wait_done("tmo_edge");
  endtask

  task automatic test_reset_mid();
    int idx;
    idx = wa_q.size();
    do_start(5'd3);
    push_byte(8'h01);
    push_byte(8'h02);
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    push_byte(8'h03);
    byte_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err} !== 26'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b required all 0",
               {byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err});
    end
    byte_in = 8'h04;
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wa_q.size() - idx != 1 || wd_q[idx] !== 16'h0102 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_writes: writes=%0d data=%h hold=%b required 1/0102/0",
               wa_q.size() - idx, wd_q[idx], cpu_hold);
    end
    do_start(5'd1);
    push_byte(8'h77);
    push_byte(8'h88);
    byte_valid = 1'b0;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 16'h7788}) begin
      n_fail++;
      $display("FAIL rstmid_reload: en=%b addr=%0d data=%h required 1/0/7788", wr_en, wr_addr,
               wr_data);
    end
    wait_done("rstmid");
  endtask

  task automatic test_start_during_load();
    do_start(5'd2);
    push_byte(8'hC3);
    byte_valid = 1'b0;
    num_words = 5'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if ({byte_ready, busy, done} !== 3'b110 || wr_data[15:8] !== 8'hC3) begin
      n_fail++;
      $display("FAIL sdl_lo: ready/busy/done=%b hi=%h required 110/c3",
               {byte_ready, busy, done}, wr_data[15:8]);
    end
    push_byte(8'h3C);
    byte_valid = 1'b0;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd0, 16'hC33C}) begin
      n_fail++;
      $display("FAIL sdl_w0: en=%b addr=%0d data=%h required 1/0/c33c", wr_en, wr_addr, wr_data);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if ({byte_ready, done, wr_addr} !== {2'b10, 4'd1}) begin
      n_fail++;
      $display("FAIL sdl_hi: ready/done=%b addr=%0d required 10/1", {byte_ready, done}, wr_addr);
    end
    push_byte(8'h5A);
    push_byte(8'hA5);
    byte_valid = 1'b0;
    n_cmp++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd1, 16'h5AA5}) begin
      n_fail++;
      $display("FAIL sdl_w1: en=%b addr=%0d data=%h required 1/1/5aa5", wr_en, wr_addr, wr_data);
    end
    wait_done("sdl");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_word();
    test_count(5'd16, "full16");
    test_count(5'd20, "clamp20");
    test_zero();
    test_gaps();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_start_during_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
